// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage data-memory controller.
// State encoding, default widths and the load-abort fill value.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_DATA_W-1:0] ALL_ONES = '1;

endpackage

// File: rtl/dmem_lastread_buf.sv
// One-entry last-load buffer (valid, addr, data) for zero-stall repeat loads.
// Only compiled and instantiated when DMEM_LASTREAD_EN is defined.
`ifdef DMEM_LASTREAD_EN
module dmem_lastread_buf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_addr,
    input  logic [DATA_W-1:0] update_data,
    input  logic              clear
);

    logic              entry_valid;
    logic [ADDR_W-1:0] entry_addr;
    logic [DATA_W-1:0] entry_data;

    assign hit      = entry_valid && (lookup_addr == entry_addr);
    assign hit_data = entry_data;

    // A completed store only refreshes data when it targets the cached address.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            entry_valid <= 1'b0;
            entry_addr  <= '0;
            entry_data  <= '0;
        end else if (fill_en) begin
            entry_valid <= 1'b1;
            entry_addr  <= fill_addr;
            entry_data  <= fill_data;
        end else if (update_en && entry_valid && (update_addr == entry_addr)) begin
            entry_data <= update_data;
        end
    end

endmodule
`endif

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: handshakes EX/MEM load/store requests with a variable-latency memory.
// Optional DMEM_LASTREAD_EN adds a one-entry last-load buffer for zero-stall repeat loads.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [ADDR_W-1:0] MEM_ALU_result,
    input  logic [DATA_W-1:0] MEM_data_write,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              mem_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    state_t            state, state_next;
    logic [7:0]        count;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              err_q;

    logic              req;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              issue;
    logic              complete;
    logic              timeout;

    assign req      = MEM_MemRead | MEM_MemWrite;
    assign issue    = !rst && (state == IDLE) && req && !hit;
    assign complete = (state == BUSY) && mem_data_valid;
    assign timeout  = (state == BUSY) && !mem_data_valid
                      && (count == 8'(TIMEOUT_CYCLES - 1));

`ifdef DMEM_LASTREAD_EN
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

    dmem_lastread_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lastread_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (MEM_ALU_result),
        .hit         (buf_hit),
        .hit_data    (buf_data),
        .fill_en     (complete && !wr_q),
        .fill_addr   (addr_q),
        .fill_data   (mem_rdata),
        .update_en   (complete && wr_q),
        .update_addr (addr_q),
        .update_data (wdata_q),
        .clear       (timeout)
    );

    assign hit      = !rst && (state == IDLE) && MEM_MemRead && !MEM_MemWrite && buf_hit;
    assign hit_data = buf_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = BUSY;
            BUSY:    if (complete || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The request is presented to memory in the same cycle it is accepted,
    // so the address/data bypass the latches while mem_en is high.
    assign mem_en    = issue;
    assign mem_wr    = issue ? MEM_MemWrite   : wr_q;
    assign mem_addr  = issue ? MEM_ALU_result : addr_q;
    assign mem_wdata = issue ? MEM_data_write : wdata_q;
    assign stall     = issue || (state == BUSY);
    assign data_out  = hit ? hit_data : data_q;
    assign mem_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (issue) begin
                addr_q  <= MEM_ALU_result;
                wdata_q <= MEM_data_write;
                wr_q    <= MEM_MemWrite;
                count   <= '0;
                if (MEM_MemRead && MEM_MemWrite) err_q <= 1'b1;
            end
            if (state == BUSY) count <= count + 8'd1;
            if (complete && !wr_q) data_q <= mem_rdata;
            if (timeout) begin
                err_q  <= 1'b1;
                data_q <= {DATA_W{ALL_ONES[0]}};
            end
            if (hit) data_q <= hit_data;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, random transactions
// against a transaction-level model, and hand-written reset/back-to-back/buffer sequences.
module tb_dmem_access_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int NO_RESP = -1;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_MemRead, MEM_MemWrite;
    logic [AW-1:0] MEM_ALU_result;
    logic [DW-1:0] MEM_data_write;
    logic [DW-1:0] data_out;
    logic          stall, mem_err, mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_data_valid;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_MemWrite   (MEM_MemWrite),
        .MEM_ALU_result (MEM_ALU_result),
        .MEM_data_write (MEM_data_write),
        .data_out       (data_out),
        .stall          (stall),
        .mem_err        (mem_err),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid)
    );

    int checks = 0;
    int passed = 0;

    // Transaction-level reference state: last load result, sticky error, buffer entry.
    logic [DW-1:0] m_data;
    logic          m_err;
    logic          m_bv;
    logic [AW-1:0] m_ba;
    logic [DW-1:0] m_bd;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        int            exp_stall;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic doReset();
        rst = 1'b1;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        MEM_ALU_result = '0; MEM_data_write = '0;
        mem_rdata = '0; mem_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_data = '0; m_err = 1'b0; m_bv = 1'b0; m_ba = '0; m_bd = '0;
    endtask

    // Drives one request, plays memory with response latency lat (NO_RESP = never)
    // and observes the transaction until the first non-stall cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int lat,
                                 input logic [DW-1:0] rdata,
                                 output int stall_n, output int en_n, output logic en_wr,
                                 output logic [AW-1:0] en_addr, output logic [DW-1:0] en_wdata,
                                 output logic [DW-1:0] d_out, output logic err,
                                 output logic done_ok);
        int e;
        e = -1;
        stall_n = 0; en_n = 0; en_wr = 1'b0; en_addr = '0; en_wdata = '0;
        d_out = '0; err = 1'b0; done_ok = 1'b0;
        @(posedge clk);
        #1;
        MEM_MemRead = rd; MEM_MemWrite = wr;
        MEM_ALU_result = addr; MEM_data_write = wdata; mem_rdata = rdata;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            mem_data_valid = (e >= 0) && (lat > 0) && (c == e + lat);
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                e = c;
                en_wr = mem_wr; en_addr = mem_addr; en_wdata = mem_wdata;
            end
            if (stall) stall_n++;
            else begin
                d_out = data_out;
                err = mem_err;
                done_ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; mem_data_valid = 1'b0;
    endtask

    // Advances the model by one transaction and checks the DUT against it.
    task automatic runAndCheck(input string name, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int lat, input logic [DW-1:0] rdata);
        int stall_n, en_n, exp_stall, exp_en;
        logic en_wr, err, done_ok, hit, responds;
        logic [AW-1:0] en_addr;
        logic [DW-1:0] en_wdata, d_out;
        hit = 1'b0;
`ifdef DMEM_LASTREAD_EN
        hit = rd && !wr && m_bv && (m_ba == addr);
`endif
        if (hit) begin
            exp_stall = 0; exp_en = 0; m_data = m_bd;
        end else begin
            exp_en = 1;
            responds = (lat >= 1) && (lat <= TO);
            exp_stall = responds ? lat + 1 : TO + 1;
            if (rd && wr) m_err = 1'b1;
            if (responds) begin
                if (!wr) begin
                    m_data = rdata; m_bv = 1'b1; m_ba = addr; m_bd = rdata;
                end else if (m_bv && m_ba == addr) begin
                    m_bd = wdata;
                end
            end else begin
                m_err = 1'b1; m_data = '1; m_bv = 1'b0;
            end
        end
        applyStimulus(rd, wr, addr, wdata, lat, rdata, stall_n, en_n, en_wr, en_addr,
                      en_wdata, d_out, err, done_ok);
        checkOutput({name, " done"}, 32'(done_ok), 32'd1);
        checkOutput({name, " stall"}, stall_n, exp_stall);
        checkOutput({name, " mem_en"}, en_n, exp_en);
        if (exp_en == 1) begin
            checkOutput({name, " mem_wr"}, 32'(en_wr), 32'(wr));
            checkOutput({name, " mem_addr"}, 32'(en_addr), 32'(addr));
            if (wr) checkOutput({name, " mem_wdata"}, 32'(en_wdata), 32'(wdata));
        end
        checkOutput({name, " data_out"}, 32'(d_out), 32'(m_data));
        checkOutput({name, " mem_err"}, 32'(err), 32'(m_err));
    endtask

    initial begin
        vec_t vecs[6];
        int stall_n, en_n, en_cnt, last_en;
        logic en_wr, err, done_ok;
        logic [AW-1:0] en_addr;
        logic [DW-1:0] en_wdata, d_out;

        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 3,       16'hBEEF, 4, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 1,       16'h0000, 2, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0080, 16'h0000, NO_RESP, 16'h0000, 9, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'hA5A5, 2,       16'h1111, 3, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1,       16'h0F0F, 2, 16'h0F0F, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0032, 16'h0000, 8,       16'h7777, 9, 16'h7777, 1'b1};

        doReset();
        @(negedge clk);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset data_out", 32'(data_out), 32'd0);
        checkOutput("reset mem_err", 32'(mem_err), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                          vecs[i].rdata, stall_n, en_n, en_wr, en_addr, en_wdata, d_out,
                          err, done_ok);
            checkOutput($sformatf("vec%0d done", i), 32'(done_ok), 32'd1);
            checkOutput($sformatf("vec%0d stall", i), stall_n, vecs[i].exp_stall);
            checkOutput($sformatf("vec%0d mem_en", i), en_n, 1);
            checkOutput($sformatf("vec%0d mem_wr", i), 32'(en_wr), 32'(vecs[i].wr));
            checkOutput($sformatf("vec%0d mem_addr", i), 32'(en_addr), 32'(vecs[i].addr));
            if (vecs[i].wr)
                checkOutput($sformatf("vec%0d mem_wdata", i), 32'(en_wdata),
                            32'(vecs[i].wdata));
            checkOutput($sformatf("vec%0d data_out", i), 32'(d_out), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d mem_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Reset during BUSY, stale response two cycles later must be ignored.
        doReset();
        @(posedge clk);
        #1 MEM_MemRead = 1'b1; MEM_ALU_result = 16'h0050;
        @(negedge clk);
        checkOutput("rst-mid mem_en", 32'(mem_en), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; MEM_MemRead = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid stall", 32'(stall), 32'd0);
        checkOutput("rst-mid data_out", 32'(data_out), 32'd0);
        @(posedge clk);
        #1 mem_data_valid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        checkOutput("stale stall", 32'(stall), 32'd0);
        checkOutput("stale mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1 mem_data_valid = 1'b0;
        @(negedge clk);
        checkOutput("stale data_out", 32'(data_out), 32'd0);
        checkOutput("stale mem_err", 32'(mem_err), 32'd0);

        // Back-to-back loads with the request held: one mem_en per IDLE, DONE ignored.
        doReset();
        en_cnt = 0; last_en = -10;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            MEM_MemRead = 1'b1;
            MEM_ALU_result = 16'h0100 + 16'(c * 2);
            mem_rdata = 16'h2000 + 16'(c);
            mem_data_valid = (c == last_en + 1);
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                last_en = c;
            end
            if (c == 8) checkOutput("b2b data_out", 32'(data_out), 32'h2007);
        end
        @(posedge clk);
        #1 MEM_MemRead = 1'b0; mem_data_valid = 1'b0;
        checkOutput("b2b mem_en count", en_cnt, 3);

`ifdef DMEM_LASTREAD_EN
        doReset();
        runAndCheck("buf fill",   1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF);
        runAndCheck("buf hit",    1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'h0BAD);
        runAndCheck("buf store",  1'b0, 1'b1, 16'h0040, 16'h5555, 1, 16'h0000);
        runAndCheck("buf hit2",   1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h0BAD);
`endif

        // Random transactions against the model; small address pool exercises the buffer.
        doReset();
        for (int i = 0; i < 60; i++) begin
            logic rd, wr;
            int op, lat;
            op = int'($urandom_range(0, 9));
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            lat = int'($urandom_range(1, 6));
            if (rd && !wr && $urandom_range(0, 9) == 0) lat = NO_RESP;
            runAndCheck($sformatf("rnd%0d", i), rd, wr,
                        16'h0040 + 16'($urandom_range(0, 3) * 2),
                        16'($urandom), lat, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
